// File: rtl/fc_ctrl_pkg.sv
// Shared types and sizes for the fc layer ping-pong controller.
package fc_ctrl_pkg;

  localparam int unsigned M         = 6;
  localparam int unsigned N         = 8;
  localparam int unsigned LOGSIZE_M = $clog2(M * N);
  localparam int unsigned LOGSIZE_N = $clog2(N);
  localparam int unsigned ROW_W     = $clog2(M);

  typedef enum logic [1:0] {
    C_IDLE,
    C_ISSUE,
    C_DRAIN,
    C_OUT
  } comp_state_t;

  // Row-major W-ROM address for (row, col).
  function automatic logic [LOGSIZE_M-1:0] w_addr(input logic [ROW_W-1:0]     row,
                                                   input logic [LOGSIZE_N-1:0] col);
    return LOGSIZE_M'(row) * LOGSIZE_M'(N) + LOGSIZE_M'(col);
  endfunction

endpackage

// File: rtl/fc_vec_loader.sv
// Load side of the 2-bank x-memory: element counter, write bank select and per-bank full flags.
module fc_vec_loader
  import fc_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 input_valid,
  output logic                 input_ready,
  output logic                 wr_en_x,
  output logic                 wr_bank,
  output logic [LOGSIZE_N-1:0] wr_addr_x,
  input  logic                 release_i,
  input  logic                 release_bank,
  output logic [1:0]           full
);

  logic [1:0]           full_q,    full_d;
  logic                 wr_bank_q, wr_bank_d;
  logic [LOGSIZE_N-1:0] wr_addr_q, wr_addr_d;

  // Ready is held low while reset is asserted so no element is accepted.
  always_comb begin
    input_ready = reset & ~full_q[wr_bank_q];
    wr_en_x     = input_valid & input_ready;
    full_d      = full_q;
    wr_bank_d   = wr_bank_q;
    wr_addr_d   = wr_addr_q;
    if (release_i) begin
      full_d[release_bank] = 1'b0;
    end
    if (wr_en_x) begin
      if (wr_addr_q == LOGSIZE_N'(N - 1)) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_addr_d         = '0;
      end else begin
        wr_addr_d = wr_addr_q + LOGSIZE_N'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      wr_addr_q <= '0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      wr_addr_q <= wr_addr_d;
    end
  end

  assign wr_bank   = wr_bank_q;
  assign wr_addr_x = wr_addr_q;
  assign full      = full_q;

endmodule

// File: rtl/fc_pingpong_ctrl.sv
// Sequencer for a double-buffered fc layer: loads vector k+1 into one bank while the
// compute FSM walks all M rows of W against vector k in the other bank.
module fc_pingpong_ctrl
  import fc_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 input_valid,
  output logic                 input_ready,
  output logic                 wr_en_x,
  output logic                 wr_bank,
  output logic [LOGSIZE_N-1:0] wr_addr_x,
  output logic                 rd_bank,
  output logic [LOGSIZE_N-1:0] rd_addr_x,
  output logic [LOGSIZE_M-1:0] addr_w,
  output logic                 clear_acc,
  output logic                 en_acc,
  output logic                 output_valid,
  input  logic                 output_ready
);

  comp_state_t          state_q,   state_d;
  logic [ROW_W-1:0]     row_q,     row_d;
  logic [LOGSIZE_N-1:0] col_q,     col_d;
  logic                 rd_bank_q, rd_bank_d;
  logic                 en_acc_q,  en_acc_d;
  logic                 release_c;
  logic                 issue_c;
  logic [1:0]           full_c;

  fc_vec_loader u_loader (
    .clk          (clk),
    .reset        (reset),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .wr_en_x      (wr_en_x),
    .wr_bank      (wr_bank),
    .wr_addr_x    (wr_addr_x),
    .release_i    (release_c),
    .release_bank (rd_bank_q),
    .full         (full_c)
  );

  // Compute FSM: N issue cycles, one drain cycle for the last product, then hold the row.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    rd_bank_d = rd_bank_q;
    release_c = 1'b0;
    issue_c   = 1'b0;
    case (state_q)
      C_IDLE: begin
        if (full_c[rd_bank_q]) begin
          state_d = C_ISSUE;
          row_d   = '0;
          col_d   = '0;
        end
      end
      C_ISSUE: begin
        issue_c = 1'b1;
        if (col_q == LOGSIZE_N'(N - 1)) begin
          col_d   = '0;
          state_d = C_DRAIN;
        end else begin
          col_d = col_q + LOGSIZE_N'(1);
        end
      end
      C_DRAIN: begin
        state_d = C_OUT;
      end
      C_OUT: begin
        if (output_ready) begin
          if (row_q == ROW_W'(M - 1)) begin
            release_c = 1'b1;
            rd_bank_d = ~rd_bank_q;
            state_d   = C_IDLE;
          end else begin
            row_d   = row_q + ROW_W'(1);
            state_d = C_ISSUE;
          end
        end
      end
      default: begin
        state_d = C_IDLE;
      end
    endcase
    // Memory and ROM data arrive one cycle after the address.
    en_acc_d = issue_c;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= C_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      rd_bank_q <= 1'b0;
      en_acc_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      rd_bank_q <= rd_bank_d;
      en_acc_q  <= en_acc_d;
    end
  end

  assign rd_bank      = rd_bank_q;
  assign rd_addr_x    = col_q;
  assign addr_w       = w_addr(row_q, col_q);
  assign clear_acc    = (state_q == C_ISSUE) && (col_q == '0);
  assign en_acc       = en_acc_q;
  assign output_valid = (state_q == C_OUT);

endmodule
